// File: rtl/alu_pkg.sv
// Shared constants for the pipelined ALU: opcodes, flag bit positions, FSM encoding.
package alu_pkg;

  // Opcode values (compared against the OPW-bit op port after a width cast)
  localparam int unsigned OP_NOT = 0;
  localparam int unsigned OP_ADD = 1;
  localparam int unsigned OP_SUB = 2;
  localparam int unsigned OP_MUL = 3;
  localparam int unsigned OP_DIV = 4;
  localparam int unsigned OP_AND = 5;
  localparam int unsigned OP_OR  = 6;
  localparam int unsigned OP_XOR = 7;

  // Bit positions inside the 8-bit flag register
  localparam int unsigned FLG_C   = 0;
  localparam int unsigned FLG_P   = 1;
  localparam int unsigned FLG_AC  = 2;
  localparam int unsigned FLG_Z   = 3;
  localparam int unsigned FLG_S   = 4;
  localparam int unsigned FLG_V   = 5;
  localparam int unsigned FLG_ILL = 6;
  localparam int unsigned FLG_DZ  = 7;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide sharing one
// shift register pair and one adder/subtractor. WIDTH iterations after start;
// done pulses for one cycle once the result is final.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi, lo, m;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             div_q;
  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   opnd_x, opnd_y, addsub;
  logic             ge;

  // One iteration step: add (mul) or trial-subtract (div) on the shared adder
  always_comb begin
    hi_n   = hi;
    lo_n   = lo;
    ge     = 1'b0;
    opnd_x = div_q ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    opnd_y = div_q ? ~{1'b0, m} : (lo[0] ? {1'b0, m} : '0);
    addsub = opnd_x + opnd_y + (WIDTH+1)'(div_q);
    if (div_q) begin
      ge   = ~addsub[WIDTH];
      hi_n = ge ? addsub[WIDTH-1:0] : opnd_x[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ge};
    end else begin
      hi_n = addsub[WIDTH:1];
      lo_n = {addsub[0], lo[WIDTH-1:1]};
    end
  end

  // Operand latch, iteration counter and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      div_q <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        hi    <= '0;
        lo    <= a;
        m     <= b;
        div_q <= mode;
        cnt   <= CW'(WIDTH);
        busy  <= 1'b1;
      end else if (busy) begin
        hi  <= hi_n;
        lo  <= lo_n;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Product is {hi,lo}; division leaves quotient in lo and remainder in hi
  assign result = div_q ? {lo, hi} : {hi, lo};

endmodule

// File: rtl/alu_seq_param.sv
// Pipelined WIDTH-bit ALU with valid/ready handshakes. Logic ops, add and sub
// finish in one cycle; MUL/DIV run on the iterative engine.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic [7:0]           flag
);

  localparam int unsigned RW = 2 * WIDTH;

  logic [0:0]       state, state_n;
  logic [RW-1:0]    out_n, sc_out, md_result;
  logic [7:0]       flag_n, sc_flag, md_flag;
  logic             out_valid_n, md_div, md_div_n;
  logic             accept, is_muldiv, md_start, md_done, lo_zp;
  logic [WIDTH:0]   add_full;
  logic [4:0]       add_nib;
  logic [WIDTH-1:0] sub_res, lo_res;

  assign in_ready = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_muldiv;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .mode   (op == OPW'(OP_DIV)),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  // Single-cycle result and flags, plus MUL/DIV dispatch decode
  always_comb begin
    sc_out    = '0;
    sc_flag   = '0;
    lo_res    = '0;
    lo_zp     = 1'b0;
    is_muldiv = 1'b0;
    add_full  = {1'b0, a} + {1'b0, b};
    add_nib   = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    sub_res   = a - b;
    case (op)
      OPW'(OP_NOT): begin
        sc_out         = {~a, ~b};
        sc_flag[FLG_Z] = (sc_out == '0);
        sc_flag[FLG_P] = ~^sc_out;
      end
      OPW'(OP_ADD): begin
        lo_res          = add_full[WIDTH-1:0];
        lo_zp           = 1'b1;
        sc_flag[FLG_C]  = add_full[WIDTH];
        sc_flag[FLG_AC] = add_nib[4];
        sc_flag[FLG_S]  = lo_res[WIDTH-1];
        sc_flag[FLG_V]  = (a[WIDTH-1] == b[WIDTH-1]) && (lo_res[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(OP_SUB): begin
        lo_res          = sub_res;
        lo_zp           = 1'b1;
        sc_flag[FLG_C]  = (a < b);
        sc_flag[FLG_AC] = (a[3:0] < b[3:0]);
        sc_flag[FLG_S]  = lo_res[WIDTH-1];
        sc_flag[FLG_V]  = (a[WIDTH-1] != b[WIDTH-1]) && (lo_res[WIDTH-1] != a[WIDTH-1]);
      end
      OPW'(OP_MUL): is_muldiv = 1'b1;
      OPW'(OP_DIV): begin
        if (b == '0) begin
          sc_out          = {{WIDTH{1'b1}}, a};
          sc_flag[FLG_DZ] = 1'b1;
        end else begin
          is_muldiv = 1'b1;
        end
      end
      OPW'(OP_AND): begin lo_res = a & b; lo_zp = 1'b1; end
      OPW'(OP_OR):  begin lo_res = a | b; lo_zp = 1'b1; end
      OPW'(OP_XOR): begin lo_res = a ^ b; lo_zp = 1'b1; end
      default: sc_flag[FLG_ILL] = 1'b1;
    endcase
    if (lo_zp) begin
      sc_out         = {{WIDTH{1'b0}}, lo_res};
      sc_flag[FLG_Z] = (lo_res == '0);
      sc_flag[FLG_P] = ~^lo_res;
    end
  end

  // Flags for the engine result, selected by the latched mode
  always_comb begin
    md_flag = '0;
    md_flag[FLG_P] = ~^md_result;
    if (md_div) begin
      md_flag[FLG_Z] = (md_result[RW-1:WIDTH] == '0);
    end else begin
      md_flag[FLG_C] = |md_result[RW-1:WIDTH];
      md_flag[FLG_S] = md_result[RW-1];
      md_flag[FLG_Z] = (md_result == '0);
    end
  end

  // Next-state and output-register loading
  always_comb begin
    state_n     = state;
    out_n       = out;
    flag_n      = flag;
    out_valid_n = out_valid;
    md_div_n    = md_div;
    if (out_valid && out_ready) out_valid_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_muldiv) begin
            state_n  = ST_BUSY;
            md_div_n = (op == OPW'(OP_DIV));
          end else begin
            out_n       = sc_out;
            flag_n      = sc_flag;
            out_valid_n = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          out_n       = md_result;
          flag_n      = md_flag;
          out_valid_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out       <= '0;
      flag      <= '0;
      out_valid <= 1'b0;
      md_div    <= 1'b0;
    end else begin
      state     <= state_n;
      out       <= out_n;
      flag      <= flag_n;
      out_valid <= out_valid_n;
      md_div    <= md_div_n;
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param (WIDTH=8, OPW=4).
module tb_alu_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [7:0]  flag;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq_param #(.WIDTH(8), .OPW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flag      (flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a single-cycle op and check the result the cycle after accept
  task automatic single(input string tag, input logic [3:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] eo, input logic [7:0] ef);
    chk({tag, "_in_ready"}, 16'(in_ready), 16'h1);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, 16'(out_valid), 16'h1);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_flag"}, 16'(flag), 16'(ef));
  endtask

  // Issue a MUL/DIV and check WIDTH+1 cycle latency with in_ready low while busy
  task automatic multi(input string tag, input logic [3:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic [15:0] eo, input logic [7:0] ef);
    chk({tag, "_in_ready"}, 16'(in_ready), 16'h1);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk({tag, "_busy_in_ready"}, 16'(in_ready), 16'h0);
      chk({tag, "_busy_out_valid"}, 16'(out_valid), 16'h0);
      tick();
    end
    chk({tag, "_c9_out_valid"}, 16'(out_valid), 16'h0);
    tick();
    chk({tag, "_out_valid"}, 16'(out_valid), 16'h1);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_flag"}, 16'(flag), 16'(ef));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    tick();
    tick();
    chk("rst_in_ready", 16'(in_ready), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out", out, 16'h0000);
    chk("rst_flag", 16'(flag), 16'h00);
    rst = 1'b0;
    #1;

    // ADD / SUB boundary cases
    single("add_ff_01", 4'd1, 8'hFF, 8'h01, 16'h0000, 8'h0F);
    tick();
    chk("add_drain_out_valid", 16'(out_valid), 16'h0);
    single("sub_10_20", 4'd2, 8'h10, 8'h20, 16'h00F0, 8'h13);

    // Iterative engine
    multi("mul_ff_ff", 4'd3, 8'hFF, 8'hFF, 16'hFE01, 8'h13);
    multi("div_200_7", 4'd4, 8'd200, 8'd7, 16'h1C04, 8'h02);
    single("div_by_zero", 4'd4, 8'h55, 8'h00, 16'hFF55, 8'h80);
    tick();

    // Backpressure: result held while out_ready low
    out_ready = 1'b0;
    single("and_f0_3c", 4'd5, 8'hF0, 8'h3C, 16'h0030, 8'h02);
    op = 4'd7; a = 8'hAA; b = 8'h0F; in_valid = 1'b1;
    #1;
    chk("hold_in_ready", 16'(in_ready), 16'h0);
    tick();
    tick();
    chk("hold_out_valid", 16'(out_valid), 16'h1);
    chk("hold_out", out, 16'h0030);
    chk("hold_flag", 16'(flag), 16'h02);
    chk("hold_in_ready2", 16'(in_ready), 16'h0);
    out_ready = 1'b1;
    #1;

    // Back-to-back stream, one accept per cycle
    single("xor_aa_0f", 4'd7, 8'hAA, 8'h0F, 16'h00A5, 8'h02);
    single("or_0f_f0", 4'd6, 8'h0F, 8'hF0, 16'h00FF, 8'h02);
    single("add_7f_01", 4'd1, 8'h7F, 8'h01, 16'h0080, 8'h34);
    single("not_00_ff", 4'd0, 8'h00, 8'hFF, 16'hFF00, 8'h02);

    // Reset in the middle of a MUL
    op = 4'd3; a = 8'h03; b = 8'h05; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", 16'(out_valid), 16'h0);
    chk("midrst_out", out, 16'h0000);
    chk("midrst_flag", 16'(flag), 16'h00);
    chk("midrst_in_ready_during", 16'(in_ready), 16'h0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", 16'(in_ready), 16'h1);
    for (int k = 0; k < 10; k++) tick();
    chk("midrst_no_stale_result", 16'(out_valid), 16'h0);

    // Illegal opcode
    single("illegal_f", 4'hF, 8'h12, 8'h34, 16'h0000, 8'h40);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
Parametrised, pipelined successor to the 8-bit ALU. It performs NOT, ADD, SUB, MUL, DIV, AND, OR and XOR on WIDTH-bit operands and produces a 2*WIDTH result plus an 8-bit flag register. Input and output use valid/ready handshakes. MUL and DIV run as iterative multi-cycle engines; all other ops complete in one cycle. It sits between the operand/opcode source and the result consumer in the datapath.

Parameters:
WIDTH, 8, operand width in bits (>=4; the aux-carry flag uses bit 3).
OPW, 4, opcode width (opcodes 0-7 defined; all others illegal).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  block can accept; combinational; 0 while rst=1
op  in  OPW  opcode: 0 NOT, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 AND, 6 OR, 7 XOR
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts the result
out  out  2*WIDTH  result
flag  out  8  flags: [0] carry/borrow, [1] even parity, [2] aux carry, [3] zero, [4] sign, [5] overflow, [6] illegal op, [7] divide-by-zero

Behaviour:
- Reset (synchronous, active-high): state=IDLE, out=0, flag=0, out_valid=0; any in-flight MUL/DIV is aborted. Applies mid-operation.
- FSM states: IDLE and BUSY.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept occurs when in_valid && in_ready.
- Single-cycle ops: out, flag and out_valid are registered on the accept edge, so the result is visible the cycle after accept. Back-to-back throughput is 1 per cycle while out_ready=1.
- MUL and DIV: on accept, go to BUSY and latch a/b. The engine iterates WIDTH cycles. After that, load the result, set out_valid and return to IDLE. out_valid rises WIDTH+1 cycles after accept. in_ready=0 throughout BUSY.
- The output holds stable while out_valid && !out_ready. out_valid clears on handshake unless a new result loads on the same edge.
- NOT: out={~a,~b}. Zero and parity are computed over the full 2*WIDTH bits. Bits 0, 2, 4 and 5 are 0.
- ADD: out={0,a+b}. [0]=carry out of MSB; [2]=carry out of bit 3; [5]=signed overflow; [4]=result MSB; zero and parity over the low WIDTH bits.
- SUB: out={0,a-b}, modulo 2^WIDTH. [0]=borrow (a<b unsigned); [2]=a[3:0]<b[3:0]; [5]=signed overflow; [4]=result MSB; zero and parity over the low WIDTH bits.
- MUL: unsigned, out=a*b (shift-add). [4]=out[2W-1]; [0]=upper half nonzero; zero and parity over the full product.
- DIV: unsigned restoring division. out={quotient,remainder}. [3]=quotient==0; [1]=parity over full out.
- DIV with b==0: no iteration. Result loads the cycle after accept with out={all ones, a} and flag=8'h80 only.
- AND/OR/XOR: out={0,result}. Zero and parity over the low WIDTH bits. Bits 0, 2, 4 and 5 are 0.
- Parity flag [1]=1 when the number of ones is even.
- Illegal opcode: single-cycle, out=0, flag=8'h40.

Decomposition:
- Package alu_pkg holds: opcode constants, flag bit indices (FLG_C, FLG_P, FLG_AC, FLG_Z, FLG_S, FLG_V, FLG_ILL, FLG_DZ), FSM state encoding.
- One sub-module, alu_muldiv_iter(WIDTH). Interface: start, mode (mul/div), a, b in; done, result out. It is a shared shift register plus adder/subtractor.
- The top level holds the handshake, FSM, single-cycle ops and flag generation.

Test Plan:
1. WIDTH=8, ADD a=8'hFF b=8'h01 -> out=16'h0000, flag=8'h0F, out_valid exactly 1 cycle after accept.
2. SUB a=8'h10 b=8'h20 -> out=16'h00F0, flag=8'h13 (borrow, parity, sign).
3. MUL a=8'hFF b=8'hFF -> out=16'hFE01, flag=8'h13. out_valid 9 cycles after accept; in_ready=0 for cycles 1-8.
4. DIV a=8'd200 b=8'd7 -> out=16'h1C04. Then DIV a=8'h55 b=0 -> out=16'hFF55, flag=8'h80, 1-cycle latency.
5. Hold out_ready=0 with a result pending; drive in_valid with XOR -> in_ready=0, out/flag stable. Raise out_ready -> handshake, next op accepted the same edge; stream 4 ops back-to-back with 1/cycle throughput.
6. Assert rst on MUL busy cycle 3 -> next cycle out_valid=0, out=0, flag=0, in_ready=1 after rst drops. Then run op=4'hF -> out=0, flag=8'h40.
